// File: rtl/tagged_fifo_read_requester.sv
// Purpose: issues one tag-addressed read per request to the cache FIFO and returns data, hit and timeout status.
// Latency: response valid 3 cycles after acceptance when the FIFO answers in its first WAIT cycle (4-cycle turnaround).
// Backpressure: req_ready is high only in IDLE; a pending response is held stable until rsp_ready.
module tagged_fifo_read_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit BLOCK_ON_EMPTY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  fifo_rd_en,
    output logic [TAG_WIDTH-1:0]  fifo_rd_tag,
    input  logic                  fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_hit,
    input  logic                  fifo_empty,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_timeout,
    input  logic                  clear_stats,
    output logic [31:0]           req_count,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           timeout_count
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 issue_ok;
    logic                 timer_expired;
    logic                 rsp_done;

    assign issue_ok      = !(BLOCK_ON_EMPTY && fifo_empty);
    assign timer_expired = (timer_q == TIMER_LAST);
    assign rsp_done      = (state_q == RESP) && rsp_ready;

    assign req_ready   = (state_q == IDLE);
    assign fifo_rd_en  = (state_q == ISSUE) && issue_ok;
    assign rsp_valid   = (state_q == RESP);
    assign fifo_rd_tag = tag_q;
    assign rsp_tag     = tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   if (issue_ok) state_d = WAIT;
            WAIT:    if (fifo_rd_valid || timer_expired) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completion wins over expiry when both land in the same WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            timer_q     <= '0;
            rsp_data    <= '0;
            rsp_hit     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) tag_q <= req_tag;
                end
                ISSUE: begin
                    if (issue_ok) timer_q <= '0;
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (fifo_rd_valid) begin
                        rsp_data    <= fifo_rd_data;
                        rsp_hit     <= fifo_rd_hit;
                        rsp_timeout <= 1'b0;
                    end else if (timer_expired) begin
                        rsp_data    <= '0;
                        rsp_hit     <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_count     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            timeout_count <= '0;
        end else if (clear_stats) begin
            req_count     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            timeout_count <= '0;
        end else if (rsp_done) begin
            req_count <= sat_inc(req_count);
            if (rsp_timeout) begin
                timeout_count <= sat_inc(timeout_count);
            end else if (rsp_hit) begin
                hit_count <= sat_inc(hit_count);
            end else begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end

endmodule

// File: tb/tb_tagged_fifo_read_requester.sv
// Directed bench for tagged_fifo_read_requester: inputs change 1ns after each rising edge,
// outputs are checked in the same window once the edge has settled.
module tb_tagged_fifo_read_requester;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_tag;
    logic        fifo_rd_valid;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_hit;
    logic        fifo_empty;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        rsp_hit;
    logic        rsp_timeout;
    logic        clear_stats;
    logic [31:0] req_count;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] timeout_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    tagged_fifo_read_requester #(
        .DATA_WIDTH(32),
        .TAG_WIDTH(8),
        .TIMEOUT_CYCLES(16),
        .BLOCK_ON_EMPTY(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_ready(req_ready),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_tag(fifo_rd_tag),
        .fifo_rd_valid(fifo_rd_valid),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_hit(fifo_rd_hit),
        .fifo_empty(fifo_empty),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag),
        .rsp_data(rsp_data),
        .rsp_hit(rsp_hit),
        .rsp_timeout(rsp_timeout),
        .clear_stats(clear_stats),
        .req_count(req_count),
        .hit_count(hit_count),
        .miss_count(miss_count),
        .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int r, input int h, input int m, input int t);
        check({tag, ".req_count"}, req_count, r);
        check({tag, ".hit_count"}, hit_count, h);
        check({tag, ".miss_count"}, miss_count, m);
        check({tag, ".timeout_count"}, timeout_count, t);
    endtask

    // Accept a request and step into WAIT, checking the single read strobe on the way.
    task automatic issue_req(input string tag, input logic [7:0] t);
        req_valid = 1'b1;
        req_tag   = t;
        tick();
        req_valid = 1'b0;
        check({tag, ".rd_en"}, fifo_rd_en, 1);
        check({tag, ".rd_tag"}, fifo_rd_tag, t);
        check({tag, ".req_ready_busy"}, req_ready, 0);
        tick();
        check({tag, ".rd_en_single"}, fifo_rd_en, 0);
    endtask

    int          t_first;
    int          t_prev;
    logic [7:0]  b2b_tags [3];

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_tag       = '0;
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = '0;
        fifo_rd_hit   = 1'b0;
        fifo_empty    = 1'b0;
        rsp_ready     = 1'b0;
        clear_stats   = 1'b0;
        b2b_tags[0]   = 8'h11;
        b2b_tags[1]   = 8'h22;
        b2b_tags[2]   = 8'h33;

        repeat (3) tick();
        check("reset.req_ready", req_ready, 1);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rd_en", fifo_rd_en, 0);
        check("reset.rsp_tag", rsp_tag, 0);
        check_counts("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Basic hit: response in the 4th cycle counting the accept cycle as 1.
        issue_req("hit", 8'h5A);
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'hDEAD_BEEF;
        fifo_rd_hit   = 1'b1;
        tick();
        fifo_rd_valid = 1'b0;
        check("hit.rsp_valid", rsp_valid, 1);
        check("hit.rsp_tag", rsp_tag, 8'h5A);
        check("hit.rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("hit.rsp_hit", rsp_hit, 1);
        check("hit.rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hit.rsp_valid_fall", rsp_valid, 0);
        check("hit.req_ready", req_ready, 1);
        check_counts("hit", 1, 1, 0, 0);

        // Miss held under response backpressure.
        issue_req("miss", 8'h3C);
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'h1234_5678;
        fifo_rd_hit   = 1'b0;
        tick();
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            check("bp.rsp_valid", rsp_valid, 1);
            check("bp.rsp_data", rsp_data, 32'h1234_5678);
            check("bp.rsp_hit", rsp_hit, 0);
            check("bp.rsp_tag", rsp_tag, 8'h3C);
            check("bp.req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_counts("miss", 2, 1, 1, 0);

        // Timeout: 16 WAIT cycles without completion.
        issue_req("tmo", 8'h77);
        check("tmo.wait_entry", rsp_valid, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo.waiting", rsp_valid, 0);
        end
        tick();
        check("tmo.rsp_valid", rsp_valid, 1);
        check("tmo.rsp_timeout", rsp_timeout, 1);
        check("tmo.rsp_data", rsp_data, 0);
        check("tmo.rsp_hit", rsp_hit, 0);
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'hCAFE_F00D;
        fifo_rd_hit   = 1'b1;
        tick();
        check("stray.rsp_data", rsp_data, 0);
        check("stray.rsp_timeout", rsp_timeout, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        fifo_rd_valid = 1'b0;
        check("stray.req_ready", req_ready, 1);
        check("stray.rsp_valid", rsp_valid, 0);
        check_counts("tmo", 3, 1, 1, 1);

        // Blocked issue while FIFO is empty: no strobe, no timeout.
        fifo_empty = 1'b1;
        req_valid  = 1'b1;
        req_tag    = 8'h44;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("blk.rd_en", fifo_rd_en, 0);
            check("blk.rsp_valid", rsp_valid, 0);
            tick();
        end
        fifo_empty = 1'b0;
        #1;
        check("blk.rd_en_release", fifo_rd_en, 1);
        check("blk.rd_tag", fifo_rd_tag, 8'h44);
        tick();
        check("blk.rd_en_single", fifo_rd_en, 0);
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'hAABB_CCDD;
        fifo_rd_hit   = 1'b1;
        tick();
        fifo_rd_valid = 1'b0;
        check("blk.rsp_data", rsp_data, 32'hAABB_CCDD);
        check("blk.rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_counts("blk", 4, 2, 1, 1);

        // Back-to-back: FIFO answers every cycle, consumer always ready.
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'h0BAD_F00D;
        fifo_rd_hit   = 1'b0;
        rsp_ready     = 1'b1;
        req_valid     = 1'b1;
        t_first       = 0;
        t_prev        = 0;
        for (int k = 0; k < 3; k++) begin
            req_tag = b2b_tags[k];
            check("b2b.req_ready", req_ready, 1);
            tick();
            tick();
            tick();
            check("b2b.rsp_valid", rsp_valid, 1);
            check("b2b.rsp_tag", rsp_tag, b2b_tags[k]);
            if (k == 0) t_first = cyc;
            else check("b2b.spacing", cyc - t_prev, 4);
            t_prev = cyc;
            if (k == 2) req_valid = 1'b0;
            tick();
        end
        check("b2b.total_span", t_prev - t_first, 8);
        rsp_ready     = 1'b0;
        fifo_rd_valid = 1'b0;
        check("b2b.idle", req_ready, 1);
        check_counts("b2b", 7, 2, 4, 1);

        // Reset while waiting on the FIFO.
        issue_req("rst", 8'h99);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst.req_ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rd_en", fifo_rd_en, 0);
        check("rst.rd_tag", fifo_rd_tag, 0);
        check("rst.rsp_data", rsp_data, 0);
        check("rst.rsp_timeout", rsp_timeout, 0);
        check_counts("rst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Clear coinciding with a response handshake.
        issue_req("pre_clr", 8'h01);
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = 32'h0000_0001;
        fifo_rd_hit   = 1'b1;
        tick();
        fifo_rd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_counts("pre_clr", 1, 1, 0, 0);
        issue_req("clr", 8'h02);
        fifo_rd_valid = 1'b1;
        tick();
        fifo_rd_valid = 1'b0;
        check("clr.rsp_valid", rsp_valid, 1);
        rsp_ready   = 1'b1;
        clear_stats = 1'b1;
        tick();
        rsp_ready   = 1'b0;
        clear_stats = 1'b0;
        check_counts("clr", 0, 0, 0, 0);
        check("clr.req_ready", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
